// File: rtl/cpu31_pkg.sv
// Shared definitions for the cpu31 core: the fetch FSM state type, the
// default reset and exception vectors, and the address/instruction width.
package cpu31_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0040_0004;
  localparam int          TIMEOUT_DEF  = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_wdog.sv
// Fetch watchdog: counts consecutive unacknowledged request cycles and
// reports expiry when the current cycle is the TIMEOUT-th one.
module fetch_wdog import cpu31_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic clrn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [7:0] r_cnt;
  logic       w_expired;

  assign w_expired = (r_cnt == 8'(TIMEOUT - 1));
  assign o_expired = w_expired;

  // Wait counter: cleared on ack/redirect/exception, holds once expired so it never wraps.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en && !w_expired) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for cpu31: owns the PC, runs the req/ack
// instruction-memory handshake, buffers one instruction for decode and
// applies redirects, exception vectoring and the fetch watchdog fault.
module fetch_ctrl import cpu31_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF,
  parameter int          TIMEOUT  = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        clrn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  input  logic        exc,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fetch_fault
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic        r_fetch_fault;

  logic        w_ld_redir;
  logic        w_accept;
  logic        w_consume;
  logic        w_to_fault;
  logic        w_wdog_clr;
  logic        w_wdog_en;
  logic        w_expired;
  logic [31:0] w_redir_pc;

  // Targets are word aligned; the low two bits of a redirect are dropped.
  assign w_redir_pc = redir_pc & 32'hFFFF_FFFC;

  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign fetch_fault = r_fetch_fault;

  assign w_wdog_clr = exc | w_ld_redir | w_accept;
  assign w_wdog_en  = (r_state == FETCH) & ~w_wdog_clr;

  fetch_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .clrn      (clrn),
    .i_clr     (w_wdog_clr),
    .i_en      (w_wdog_en),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath strobes; exception beats redirect beats normal flow.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_redir  = 1'b0;
    w_accept    = 1'b0;
    w_consume   = 1'b0;
    w_to_fault  = 1'b0;
    if (exc) begin
      w_state_nxt = IDLE;
    end else if (redir_valid && (r_state != FAULT)) begin
      w_ld_redir  = 1'b1;
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            w_accept    = 1'b1;
            w_state_nxt = HOLD;
          end else if (w_expired) begin
            w_to_fault  = 1'b1;
            w_state_nxt = FAULT;
          end
        end
        HOLD: begin
          if (!stall) begin
            w_consume   = 1'b1;
            w_state_nxt = FETCH;
          end
        end
        default: begin
          w_state_nxt = FAULT;
        end
      endcase
    end
  end

  // PC, instruction buffer, valid flag and sticky fault.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_instr_pc    <= 32'd0;
      r_instr_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
    end else if (exc) begin
      r_pc          <= EXC_VEC;
      r_instr_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
    end else if (w_ld_redir) begin
      r_pc          <= w_redir_pc;
      r_instr_valid <= 1'b0;
    end else if (w_accept) begin
      r_instr       <= imem_rdata;
      r_instr_pc    <= r_pc;
      r_pc          <= r_pc + 32'd4;
      r_instr_valid <= 1'b1;
    end else if (w_consume) begin
      r_instr_valid <= 1'b0;
    end else if (w_to_fault) begin
      r_fetch_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run, all checked
// cycle by cycle against a behavioural model of the fetch sequencer.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC  = 32'h0040_0004;
  localparam int          TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        clrn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        exc;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fetch_fault;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic        m_idle;
  logic        m_req;
  logic        m_valid;
  logic        m_fault;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_instr_pc;
  int          m_wait;

  logic [130:0] w_got;
  assign w_got = {imem_req, imem_addr, pc, instr, instr_pc, instr_valid, fetch_fault};

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .EXC_VEC  (EXC_VEC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .exc         (exc),
    .pc          (pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .fetch_fault (fetch_fault)
  );

  function automatic logic [130:0] mdl_vec();
    return {m_req, m_pc, m_pc, m_instr, m_instr_pc, m_valid, m_fault};
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_req = 1'b0; m_valid = 1'b0; m_fault = 1'b0;
    m_pc = RESET_PC; m_instr = 32'd0; m_instr_pc = 32'd0; m_wait = 0;
  endtask

  // One clock of the fetch rules, applied to the inputs seen at the edge.
  task automatic model_step();
    if (exc) begin
      m_pc = EXC_VEC; m_valid = 1'b0; m_fault = 1'b0; m_wait = 0;
      m_req = 1'b0; m_idle = 1'b1;
    end else if (m_fault) begin
      m_req = 1'b0;
    end else if (redir_valid) begin
      m_pc = {redir_pc[31:2], 2'b00}; m_valid = 1'b0; m_wait = 0;
      m_req = 1'b0; m_idle = 1'b1;
    end else if (m_idle) begin
      m_idle = 1'b0; m_req = 1'b1;
    end else if (m_req) begin
      if (imem_ack) begin
        m_instr = imem_rdata; m_instr_pc = m_pc; m_pc = m_pc + 32'd4;
        m_valid = 1'b1; m_req = 1'b0; m_wait = 0;
      end else begin
        m_wait = m_wait + 1;
        if (m_wait == TIMEOUT) begin
          m_fault = 1'b1; m_req = 1'b0;
        end
      end
    end else if (m_valid && !stall) begin
      m_valid = 1'b0; m_req = 1'b1;
    end
  endtask

  task automatic drive(input logic a, input logic s, input logic r,
                       input logic [31:0] rp, input logic e);
    imem_ack = a; stall = s; redir_valid = r; redir_pc = rp; exc = e;
    imem_rdata = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    n_tests++;
    if (w_got !== mdl_vec()) begin
      n_fail++; $display("FAIL reset_state got=%h exp=%h", w_got, mdl_vec());
    end
    n_tests++;
    if ({imem_req, pc, instr_valid, fetch_fault} !== {1'b0, RESET_PC, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_values got req=%b pc=%h v=%b f=%b exp req=0 pc=%h v=0 f=0",
                         imem_req, pc, instr_valid, fetch_fault, RESET_PC);
    end
    @(negedge clk);
    clrn = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    int          nreq;
    exp_addr = RESET_PC;
    nreq = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      step();
      n_tests++;
      if (w_got !== mdl_vec()) begin
        n_fail++; $display("FAIL seq_model cyc=%0d got=%h exp=%h", i, w_got, mdl_vec());
      end
      if (imem_req) begin
        n_tests++;
        if (imem_addr !== exp_addr) begin
          n_fail++; $display("FAIL seq_addr req=%0d got=%h exp=%h", nreq, imem_addr, exp_addr);
        end
        exp_addr = exp_addr + 32'd4;
        nreq++;
      end
      if (instr_valid) begin
        n_tests++;
        if (instr_pc !== exp_addr - 32'd4) begin
          n_fail++; $display("FAIL seq_instr_pc got=%h exp=%h", instr_pc, exp_addr - 32'd4);
        end
      end
    end
    n_tests++;
    if (nreq != 4) begin
      n_fail++; $display("FAIL seq_req_count got=%0d exp=4", nreq);
    end
  endtask

  task automatic test_stall();
    logic [31:0] s_instr, s_ipc, s_pc;
    int          bound;
    bound = 0;
    while (!instr_valid && bound < 10) begin
      drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      step();
      bound++;
    end
    n_tests++;
    if (!instr_valid) begin
      n_fail++; $display("FAIL stall_reach_hold got valid=%b exp valid=1", instr_valid);
    end
    s_instr = instr; s_ipc = instr_pc; s_pc = pc;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      step();
      n_tests++;
      if ({instr, instr_pc, pc, imem_req, instr_valid} !== {s_instr, s_ipc, s_pc, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL stall_hold cyc=%0d got instr=%h ipc=%h pc=%h req=%b v=%b exp instr=%h ipc=%h pc=%h req=0 v=1",
                           i, instr, instr_pc, pc, imem_req, instr_valid, s_instr, s_ipc, s_pc);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step();
    n_tests++;
    if ({imem_req, imem_addr, instr_valid} !== {1'b1, s_ipc + 32'd4, 1'b0}) begin
      n_fail++; $display("FAIL stall_release got req=%b addr=%h v=%b exp req=1 addr=%h v=0",
                         imem_req, imem_addr, instr_valid, s_ipc + 32'd4);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] s_instr, s_ipc;
    s_instr = instr; s_ipc = instr_pc;
    drive(1'b1, 1'b0, 1'b1, 32'h0040_0103, 1'b0);
    step();
    n_tests++;
    if ({imem_req, pc, instr_valid, instr, instr_pc} !== {1'b0, 32'h0040_0100, 1'b0, s_instr, s_ipc}) begin
      n_fail++; $display("FAIL redir_discard got req=%b pc=%h v=%b instr=%h ipc=%h exp req=0 pc=00400100 v=0 instr=%h ipc=%h",
                         imem_req, pc, instr_valid, instr, instr_pc, s_instr, s_ipc);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step();
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0040_0100}) begin
      n_fail++; $display("FAIL redir_fetch got req=%b addr=%h exp req=1 addr=00400100", imem_req, imem_addr);
    end
  endtask

  task automatic test_fault();
    for (int i = 1; i <= TIMEOUT; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      step();
      n_tests++;
      if (w_got !== mdl_vec()) begin
        n_fail++; $display("FAIL fault_model cyc=%0d got=%h exp=%h", i, w_got, mdl_vec());
      end
    end
    n_tests++;
    if ({fetch_fault, imem_req} !== 2'b10) begin
      n_fail++; $display("FAIL fault_assert got fault=%b req=%b exp fault=1 req=0", fetch_fault, imem_req);
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0000_1000, 1'b0);
    step();
    n_tests++;
    if ({fetch_fault, imem_req, pc} !== {1'b1, 1'b0, 32'h0040_0100}) begin
      n_fail++; $display("FAIL fault_redir_ignored got fault=%b req=%b pc=%h exp fault=1 req=0 pc=00400100",
                         fetch_fault, imem_req, pc);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step();
    n_tests++;
    if ({fetch_fault, imem_req, pc} !== {1'b0, 1'b0, EXC_VEC}) begin
      n_fail++; $display("FAIL fault_exc_clear got fault=%b req=%b pc=%h exp fault=0 req=0 pc=%h",
                         fetch_fault, imem_req, pc, EXC_VEC);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step();
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0040_0004}) begin
      n_fail++; $display("FAIL fault_exc_fetch got req=%b addr=%h exp req=1 addr=00400004", imem_req, imem_addr);
    end
  endtask

  task automatic test_exc_wrap();
    drive(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
    step();
    n_tests++;
    if ({pc, instr_valid, imem_req} !== {EXC_VEC, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL exc_beats_redir got pc=%h v=%b req=%b exp pc=%h v=0 req=0", pc, instr_valid, imem_req, EXC_VEC);
    end
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step();
    step();
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_fail++; $display("FAIL wrap_fetch got req=%b addr=%h exp req=1 addr=fffffffc", imem_req, imem_addr);
    end
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    step();
    n_tests++;
    if ({pc, instr_pc, instr_valid} !== {32'h0000_0000, 32'hFFFF_FFFC, 1'b1}) begin
      n_fail++; $display("FAIL wrap_pc got pc=%h ipc=%h v=%b exp pc=00000000 ipc=fffffffc v=1", pc, instr_pc, instr_valid);
    end
    n_tests++;
    if (w_got !== mdl_vec()) begin
      n_fail++; $display("FAIL wrap_model got=%h exp=%h", w_got, mdl_vec());
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step();
    n_tests++;
    if (imem_req !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre got req=%b exp req=1", imem_req);
    end
    #2;
    clrn = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if (w_got !== mdl_vec()) begin
      n_fail++; $display("FAIL areset_outputs got=%h exp=%h", w_got, mdl_vec());
    end
    @(negedge clk);
    clrn = 1'b0;
    step();
    step();
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
      n_fail++; $display("FAIL areset_restart got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    int ack_pct;
    ack_pct = 70;
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) ack_pct = ($urandom_range(0, 1) == 0) ? 70 : 3;
      drive($urandom_range(0, 99) < ack_pct,
            $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 4,
            $urandom,
            $urandom_range(0, 99) < 2);
      step();
      n_tests++;
      if (w_got !== mdl_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", i, w_got, mdl_vec());
      end
    end
  endtask

  initial begin
    clrn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    model_reset();
    #12;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_fault();
    test_exc_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the 32-bit program counter of the cpu31 core and drives it through a req/ack instruction-memory interface. It holds the PC and fetched instruction, hands instructions to decode with a stall back-pressure, and applies branch/jump redirects and exception vectoring. A watchdog flags a fetch fault when memory fails to acknowledge. It sits between instruction memory and the decode stage, replacing a free-running PC register.

## Interface
- RESET_PC, 32'h0040_0000, PC loaded on reset
- EXC_VEC, 32'h0040_0004, PC loaded on exception
- TIMEOUT, 15, cycles of unacknowledged request before fault (1..255)
- clk  in  1  clock, rising edge
- clrn  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request, level, held until ack
- imem_addr  out  32  fetch address, equals pc
- imem_ack  in  1  memory acknowledge; imem_rdata valid same cycle
- imem_rdata  in  32  fetched word
- stall  in  1  decode not ready; holds current instruction
- redir_valid  in  1  branch/jump taken this cycle
- redir_pc  in  32  redirect target
- exc  in  1  exception request, highest priority
- pc  out  32  address of next fetch
- instr  out  32  fetched instruction
- instr_pc  out  32  address of instr
- instr_valid  out  1  instr available to decode
- fetch_fault  out  1  sticky watchdog fault

## Operation
- States: IDLE, FETCH, HOLD, FAULT. Moore outputs: imem_req = (state==FETCH); imem_addr = pc.
- Reset (clrn=1, async): state IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fetch_fault=0, wait counter 0.
- IDLE: next state FETCH unconditionally.
- FETCH: if imem_ack: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, instr_valid<=1, cnt<=0, -> HOLD. Else cnt<=cnt+1; when cnt==TIMEOUT-1 and no ack: fetch_fault<=1, -> FAULT.
- HOLD: instr_valid=1. Consumption = instr_valid & ~stall. On consumption: instr_valid<=0, -> FETCH. While stall=1: all state held indefinitely.
- FAULT: imem_req=0, instr_valid=0; left only via exc or reset.
- Redirect (redir_valid, no exc), any state but FAULT: pc<={redir_pc[31:2],2'b00}, instr_valid<=0, cnt<=0, -> IDLE. An ack in the same cycle is discarded (instr/instr_pc unchanged, pc takes redirect).
- Exception (exc), any state incl. FAULT: pc<=EXC_VEC, instr_valid<=0, cnt<=0, fetch_fault<=0, -> IDLE. exc beats redir_valid and imem_ack.
- Arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0. pc[1:0] always 0.
- Counter width: 8 bits; never wraps (saturation impossible since FAULT entered first).

## Timing
- First imem_req high in the 2nd rising edge after clrn deasserts (IDLE one cycle).
- Ack to instr_valid: 1 cycle (registered). Ack in first FETCH cycle gives 2 cycles/instruction minimum (FETCH, HOLD).
- Redirect/exception to new imem_addr on bus with req: 2 cycles (IDLE then FETCH); req drops for exactly one cycle, so address never changes while req is high.
- Fault asserts the cycle after the TIMEOUT-th unacknowledged FETCH cycle.
- clrn mid-transaction: req drops immediately (async); memory must abandon the request.

## Structure
- Shared package cpu31_pkg: state enum typedef (IDLE/FETCH/HOLD/FAULT), RESET_PC and EXC_VEC defaults, instruction/address width constant 32.
- One sub-module: fetch_wdog (8-bit wait counter with clear, enable, TIMEOUT compare, expiry output). FSM and registers stay in fetch_ctrl.

## Test plan
- Reset, ack every request on first FETCH cycle, stall=0 -> imem_addr 0x00400000, 0x00400004, 0x00400008 on successive requests; instr_valid every 2nd cycle; instr_pc matches.
- Stall=1 for 5 cycles while instr_valid -> instr/instr_pc stable, imem_req=0, no pc change; release -> next fetch at instr_pc+4.
- redir_valid with redir_pc=0x00400103 during FETCH with simultaneous ack -> data discarded, instr_valid=0, one idle cycle, then req at 0x00400100.
- No ack for 15 cycles -> fetch_fault=1, req=0; redirect ignored; exc -> fault clears, req at 0x00400004 two cycles later.
- exc and redir_valid same cycle -> pc=EXC_VEC; pc=0xFFFFFFFC acked -> pc wraps to 0x00000000.
- clrn pulsed mid-FETCH -> imem_req falls same cycle, all outputs at reset values, fetch restarts at RESET_PC.
